// File: rtl/pooling_layer_ctrl.sv
// -----------------------------------------------------------------------------
// pooling_layer_ctrl
//
// Sequencer for the pooling-layer datapath (row input cache -> pooling array).
// It collects POOL_SIZE conv-output rows into the cache, one row per
// kernel_calc_fin pulse. It then launches the pooling array and waits out the
// array's fixed latency. Finally it presents the pooled row downstream with a
// valid/ready handshake. This repeats until OUT_ROWS pooled rows have been
// delivered, and then layer_done pulses.
//
// Optional build macro: POOL_CTRL_PERF_EN adds a 16-bit saturating counter
// (stall_cnt). It counts cycles in which a pooled row is offered but not
// accepted.
//
// Ports:
//   clk             in   clock, rising edge
//   rst_n           in   synchronous reset, active HIGH despite the name
//   layer_start     in   pulse: begin a new feature map (honoured in IDLE only)
//   kernel_calc_fin in   pulse: a conv row is present on the cache input
//   out_ready       in   downstream accepts the presented pooled row
//   cache_clr       out  one-cycle clear of the input cache
//   cache_wr_en     out  cache writes the current row (combinational)
//   cache_row_sel   out  cache slot addressed by cache_wr_en
//   pool_start      out  one-cycle pooling-array launch
//   out_valid       out  pooled row valid
//   out_row_idx     out  index of the pooled row being presented
//   conv_hold       out  conv layer must not issue kernel_calc_fin
//   layer_busy      out  controller is not idle
//   layer_done      out  one-cycle pulse after the last row is accepted
//   err_overflow    out  sticky: a fin arrived while conv_hold was high
//   stall_cnt       out  (POOL_CTRL_PERF_EN only) back-pressure cycle count
// -----------------------------------------------------------------------------
module pooling_layer_ctrl #(
  parameter int FMAP_ROWS    = 6,
  parameter int POOL_SIZE    = 2,
  parameter int POOL_LATENCY = 2,
  localparam int OUT_ROWS    = FMAP_ROWS / POOL_SIZE,
  localparam int ROW_W       = (OUT_ROWS > 1) ? $clog2(OUT_ROWS) : 1,
  localparam int SEL_W       = (POOL_SIZE > 1) ? $clog2(POOL_SIZE) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             layer_start,
  input  logic             kernel_calc_fin,
  input  logic             out_ready,
  output logic             cache_clr,
  output logic             cache_wr_en,
  output logic [SEL_W-1:0] cache_row_sel,
  output logic             pool_start,
  output logic             out_valid,
  output logic [ROW_W-1:0] out_row_idx,
  output logic             conv_hold,
  output logic             layer_busy,
  output logic             layer_done,
`ifdef POOL_CTRL_PERF_EN
  output logic             err_overflow,
  output logic [15:0]      stall_cnt
`else
  output logic             err_overflow
`endif
);

  localparam int LAT_W = (POOL_LATENCY > 1) ? $clog2(POOL_LATENCY) : 1;

  localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(POOL_SIZE - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(OUT_ROWS - 1);
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(POOL_LATENCY - 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    FILL = 3'd1,
    POOL = 3'd2,
    OUT  = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic             clr_q, clr_d;
  logic [SEL_W-1:0] row_in_q, row_in_d;
  logic [ROW_W-1:0] out_row_q, out_row_d;
  logic [LAT_W-1:0] lat_q, lat_d;
  logic             pool_start_q, pool_start_d;
  logic             err_q, err_d;

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q      <= IDLE;
      clr_q        <= 1'b0;
      row_in_q     <= '0;
      out_row_q    <= '0;
      lat_q        <= '0;
      pool_start_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      clr_q        <= clr_d;
      row_in_q     <= row_in_d;
      out_row_q    <= out_row_d;
      lat_q        <= lat_d;
      pool_start_q <= pool_start_d;
      err_q        <= err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    clr_d        = 1'b0;
    row_in_d     = row_in_q;
    out_row_d    = out_row_q;
    lat_d        = lat_q;
    pool_start_d = 1'b0;

    case (state_q)
      IDLE: begin
        // The cache clear occupies its own cycle while still in IDLE. As a
        // result, FILL (and any cache write) starts strictly after the clear.
        if (clr_q) begin
          state_d = FILL;
        end else if (layer_start) begin
          clr_d     = 1'b1;
          row_in_d  = '0;
          out_row_d = '0;
        end
      end
      FILL: begin
        if (kernel_calc_fin) begin
          if (row_in_q == SEL_LAST) begin
            row_in_d     = '0;
            lat_d        = '0;
            pool_start_d = 1'b1;
            state_d      = POOL;
          end else begin
            row_in_d = row_in_q + 1'b1;
          end
        end
      end
      POOL: begin
        // POOL lasts exactly POOL_LATENCY cycles, starting with the
        // pool_start cycle.
        if (lat_q == LAT_LAST) begin
          state_d = OUT;
        end else begin
          lat_d = lat_q + 1'b1;
        end
      end
      OUT: begin
        if (out_ready) begin
          if (out_row_q == ROW_LAST) begin
            state_d = DONE;
          end else begin
            out_row_d = out_row_q + 1'b1;
            state_d   = FILL;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign conv_hold     = (state_q != FILL);
  assign err_d         = err_q | (kernel_calc_fin & conv_hold);
  assign cache_clr     = clr_q;
  assign cache_wr_en   = kernel_calc_fin & (state_q == FILL);
  assign cache_row_sel = row_in_q;
  assign pool_start    = pool_start_q;
  assign out_valid     = (state_q == OUT);
  assign out_row_idx   = out_row_q;
  assign layer_busy    = (state_q != IDLE);
  assign layer_done    = (state_q == DONE);
  assign err_overflow  = err_q;

`ifdef POOL_CTRL_PERF_EN
  logic [15:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if ((state_q == IDLE) && !clr_q && layer_start) begin
      stall_d = '0;
    end else if ((state_q == OUT) && !out_ready && (stall_q != 16'hFFFF)) begin
      stall_d = stall_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_pooling_layer_ctrl.sv
module tb_pooling_layer_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       layer_start;
  logic       kernel_calc_fin;
  logic       out_ready;
  logic       cache_clr;
  logic       cache_wr_en;
  logic [0:0] cache_row_sel;
  logic       pool_start;
  logic       out_valid;
  logic [1:0] out_row_idx;
  logic       conv_hold;
  logic       layer_busy;
  logic       layer_done;
  logic       err_overflow;
`ifdef POOL_CTRL_PERF_EN
  logic [15:0] stall_cnt;
`endif

  pooling_layer_ctrl #(
    .FMAP_ROWS   (6),
    .POOL_SIZE   (2),
    .POOL_LATENCY(2)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .layer_start    (layer_start),
    .kernel_calc_fin(kernel_calc_fin),
    .out_ready      (out_ready),
    .cache_clr      (cache_clr),
    .cache_wr_en    (cache_wr_en),
    .cache_row_sel  (cache_row_sel),
    .pool_start     (pool_start),
    .out_valid      (out_valid),
    .out_row_idx    (out_row_idx),
    .conv_hold      (conv_hold),
    .layer_busy     (layer_busy),
    .layer_done     (layer_done),
`ifdef POOL_CTRL_PERF_EN
    .err_overflow   (err_overflow),
    .stall_cnt      (stall_cnt)
`else
    .err_overflow   (err_overflow)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int pool_cnt = 0;
  int done_cnt = 0;
  int xfer_cnt = 0;
  int last_xfer_cyc = 0;

  // Scoreboard: expected cache slots and expected pooled-row indices.
  logic [31:0] q_sel[$];
  logic [31:0] q_row[$];
  int m_row_in = 0;
  int m_out_row = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Sampled on the falling edge, i.e. in the middle of the cycle.
  task automatic monitor();
    logic [31:0] e;
    chk("clr_wr_excl", {31'd0, cache_clr & cache_wr_en}, 32'd0);
    if (cache_wr_en) begin
      chk("sel_q_nonempty", {31'd0, q_sel.size() > 0}, 32'd1);
      if (q_sel.size() > 0) begin
        e = q_sel.pop_front();
        chk("cache_row_sel", {31'd0, cache_row_sel}, e);
      end
    end
    if (out_valid && out_ready) begin
      chk("row_q_nonempty", {31'd0, q_row.size() > 0}, 32'd1);
      if (q_row.size() > 0) begin
        e = q_row.pop_front();
        chk("out_row_idx", {30'd0, out_row_idx}, e);
      end
      xfer_cnt++;
      last_xfer_cyc = cyc;
    end
    if (pool_start) pool_cnt++;
    if (layer_done) begin
      done_cnt++;
      chk("done_after_xfer", cyc - last_xfer_cyc, 32'd1);
    end
  endtask

  // One clock cycle. Inputs are driven at posedge+1; outputs are checked at
  // the falling edge.
  task automatic step();
    @(negedge clk);
    cyc++;
    monitor();
    @(posedge clk);
    #1;
  endtask

  // Wait for FILL (bounded), then issue one fin and record its expectations.
  task automatic fin_row(input int gap);
    int i;
    for (i = 0; i < 50 && conv_hold; i++) step();
    chk("wait_fill", {31'd0, conv_hold}, 32'd0);
    q_sel.push_back(m_row_in);
    if (m_row_in == 1) begin
      m_row_in = 0;
      q_row.push_back(m_out_row);
      m_out_row++;
    end else begin
      m_row_in++;
    end
    kernel_calc_fin = 1'b1;
    step();
    kernel_calc_fin = 1'b0;
    for (int k = 0; k < gap; k++) step();
  endtask

  task automatic wait_valid();
    for (int i = 0; i < 50 && !out_valid; i++) step();
    chk("wait_valid", {31'd0, out_valid}, 32'd1);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 60 && layer_busy; i++) step();
    chk("wait_idle", {31'd0, layer_busy}, 32'd0);
  endtask

  task automatic start_layer();
    layer_start = 1'b1;
    step();
    layer_start = 1'b0;
    chk("cache_clr_pulse", {31'd0, cache_clr}, 32'd1);
    chk("hold_during_clr", {31'd0, conv_hold}, 32'd1);
    step();
    chk("cache_clr_drop", {31'd0, cache_clr}, 32'd0);
    chk("busy_fill", {31'd0, layer_busy}, 32'd1);
  endtask

  initial begin
    rst_n = 1'b1;
    layer_start = 1'b0;
    kernel_calc_fin = 1'b0;
    out_ready = 1'b1;
    step();
    step();
    rst_n = 1'b0;

    // Reset state
    chk("rst_conv_hold", {31'd0, conv_hold}, 32'd1);
    chk("rst_busy", {31'd0, layer_busy}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_cache_clr", {31'd0, cache_clr}, 32'd0);
    chk("rst_pool_start", {31'd0, pool_start}, 32'd0);
    chk("rst_done", {31'd0, layer_done}, 32'd0);
    chk("rst_err", {31'd0, err_overflow}, 32'd0);
    chk("rst_row_idx", {30'd0, out_row_idx}, 32'd0);

    // Nominal pass with latency check on row pair 0
    pool_cnt = 0; done_cnt = 0; xfer_cnt = 0;
    start_layer();
    fin_row(2);
    fin_row(0);
    chk("lat_pool_start_T1", {31'd0, pool_start}, 32'd1);
    chk("lat_valid_T1", {31'd0, out_valid}, 32'd0);
    step();
    chk("lat_pool_start_T2", {31'd0, pool_start}, 32'd0);
    chk("lat_valid_T2", {31'd0, out_valid}, 32'd0);
    step();
    chk("lat_valid_T3", {31'd0, out_valid}, 32'd1);
    for (int r = 0; r < 4; r++) fin_row(2);
    wait_idle();
    chk("nom_pool_cnt", pool_cnt, 32'd3);
    chk("nom_done_cnt", done_cnt, 32'd1);
    chk("nom_xfer_cnt", xfer_cnt, 32'd3);
    chk("nom_err", {31'd0, err_overflow}, 32'd0);
    chk("nom_q_empty", q_sel.size() + q_row.size(), 32'd0);

    // Back-pressure and ignored start
    m_row_in = 0; m_out_row = 0;
    start_layer();
    out_ready = 1'b0;
    fin_row(2);
    layer_start = 1'b1;
    step();
    layer_start = 1'b0;
    chk("ign_start_clr", {31'd0, cache_clr}, 32'd0);
    chk("ign_start_fill", {31'd0, conv_hold}, 32'd0);
    fin_row(0);
    wait_valid();
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_row_idx", {30'd0, out_row_idx}, 32'd0);
      chk("bp_hold", {31'd0, conv_hold}, 32'd1);
      step();
    end
`ifdef POOL_CTRL_PERF_EN
    chk("bp_stall_cnt", {16'd0, stall_cnt}, 32'd5);
`endif
    out_ready = 1'b1;
    chk("bp_valid_held", {31'd0, out_valid}, 32'd1);
    step();
    chk("bp_valid_drop", {31'd0, out_valid}, 32'd0);

    // Reset in the middle of OUT for row 1
    out_ready = 1'b0;
    fin_row(2);
    fin_row(0);
    wait_valid();
    chk("mid_row_idx", {30'd0, out_row_idx}, 32'd1);
    done_cnt = 0;
    rst_n = 1'b1;
    step();
    rst_n = 1'b0;
    q_sel.delete();
    q_row.delete();
    m_row_in = 0; m_out_row = 0;
    chk("abort_valid", {31'd0, out_valid}, 32'd0);
    chk("abort_busy", {31'd0, layer_busy}, 32'd0);
    chk("abort_hold", {31'd0, conv_hold}, 32'd1);
    chk("abort_row_idx", {30'd0, out_row_idx}, 32'd0);
    step(); step(); step();
    chk("abort_no_done", done_cnt, 32'd0);

    // Fresh layer, with an overflow fin issued during POOL
    out_ready = 1'b1;
    done_cnt = 0; xfer_cnt = 0;
    start_layer();
    fin_row(2);
    fin_row(0);
    kernel_calc_fin = 1'b1;
    chk("ovf_no_wr", {31'd0, cache_wr_en}, 32'd0);
    step();
    kernel_calc_fin = 1'b0;
    chk("ovf_err_set", {31'd0, err_overflow}, 32'd1);
    for (int r = 0; r < 4; r++) fin_row(2);
    wait_idle();
    chk("ovf_done_cnt", done_cnt, 32'd1);
    chk("ovf_xfer_cnt", xfer_cnt, 32'd3);
    chk("ovf_err_sticky", {31'd0, err_overflow}, 32'd1);
    rst_n = 1'b1;
    step();
    rst_n = 1'b0;
    chk("ovf_err_cleared", {31'd0, err_overflow}, 32'd0);
    chk("final_q_empty", q_sel.size() + q_row.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
